// File: rtl/mult_wallace_pipe.sv
// Three-stage pipelined WIDTH x WIDTH Wallace-tree multiplier with valid/ready
// handshakes on both sides and a per-transaction signed (Baugh-Wooley) mode.
module mult_wallace_pipe #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_signed,
  input  logic [WIDTH-1:0]       operand_a,
  input  logic [WIDTH-1:0]       operand_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_signed,
  output logic [2*WIDTH-1:0]     result
);

  localparam int unsigned RES_W  = 2 * WIDTH;
  // Column capacity: WIDTH product bits plus two correction constants at most.
  localparam int unsigned H      = WIDTH + 2;
  localparam int unsigned LAYERS = 12;

  logic                 v1, v2;
  logic [WIDTH-1:0]     a1, b1;
  logic                 sgn1, sgn2;
  logic [RES_W-1:0]     sum2, carry2;
  logic                 s1_load, s2_load, s3_load;

  always_comb begin
    s3_load  = !out_valid || out_ready;
    s2_load  = !v2 || s3_load;
    s1_load  = !v1 || s2_load;
    in_ready = s1_load;
  end

  // Partial-product matrix and Wallace reduction.
  logic [H-1:0]     col  [RES_W];
  logic [H-1:0]     nxt  [RES_W];
  int unsigned      cnt  [RES_W];
  int unsigned      ncnt [RES_W];
  logic [H-1:0]     w;
  int unsigned      rem;
  logic             busy;
  logic             pp, fs, fc;
  logic [RES_W-1:0] sum_row, carry_row;

  // Each column is kept as a packed stack: new bits shift in at bit 0 and the
  // live bits always occupy [cnt-1:0], so only constant bit selects are needed.
  always_comb begin
    for (int unsigned c = 0; c < RES_W; c++) begin
      col[c]  = '0;
      nxt[c]  = '0;
      cnt[c]  = 0;
      ncnt[c] = 0;
    end
    w         = '0;
    rem       = 0;
    busy      = 1'b0;
    pp        = 1'b0;
    fs        = 1'b0;
    fc        = 1'b0;
    sum_row   = '0;
    carry_row = '0;

    for (int unsigned i = 0; i < WIDTH; i++) begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
        pp = a1[j] & b1[i];
        if (sgn1 && ((i == WIDTH - 1) != (j == WIDTH - 1)))
          pp = ~pp;
        col[i+j] = {col[i+j][H-2:0], pp};
        cnt[i+j]++;
      end
    end
    if (sgn1) begin
      col[WIDTH]   = {col[WIDTH][H-2:0], 1'b1};
      cnt[WIDTH]++;
      col[RES_W-1] = {col[RES_W-1][H-2:0], 1'b1};
      cnt[RES_W-1]++;
    end

    for (int unsigned l = 0; l < LAYERS; l++) begin
      busy = 1'b0;
      for (int unsigned c = 0; c < RES_W; c++)
        if (cnt[c] > 2) busy = 1'b1;
      if (busy) begin
        for (int unsigned c = 0; c < RES_W; c++) begin
          nxt[c]  = '0;
          ncnt[c] = 0;
        end
        for (int unsigned c = 0; c < RES_W; c++) begin
          w   = col[c];
          rem = cnt[c];
          for (int unsigned g = 0; g < H / 3; g++) begin
            if (rem >= 3) begin
              fs = w[0] ^ w[1] ^ w[2];
              fc = (w[0] & w[1]) | (w[0] & w[2]) | (w[1] & w[2]);
              nxt[c] = {nxt[c][H-2:0], fs};
              ncnt[c]++;
              if (c + 1 < RES_W) begin
                nxt[c+1] = {nxt[c+1][H-2:0], fc};
                ncnt[c+1]++;
              end
              w   = w >> 3;
              rem = rem - 3;
            end
          end
          if (rem == 2) begin
            nxt[c] = {nxt[c][H-2:0], w[0] ^ w[1]};
            ncnt[c]++;
            if (c + 1 < RES_W) begin
              nxt[c+1] = {nxt[c+1][H-2:0], w[0] & w[1]};
              ncnt[c+1]++;
            end
          end else if (rem == 1) begin
            nxt[c] = {nxt[c][H-2:0], w[0]};
            ncnt[c]++;
          end
        end
        for (int unsigned c = 0; c < RES_W; c++) begin
          col[c] = nxt[c];
          cnt[c] = ncnt[c];
        end
      end
    end

    for (int unsigned c = 0; c < RES_W; c++) begin
      sum_row[c]   = col[c][0];
      carry_row[c] = col[c][1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      a1   <= '0;
      b1   <= '0;
      sgn1 <= 1'b0;
    end else if (s1_load) begin
      v1 <= in_valid;
      if (in_valid) begin
        a1   <= operand_a;
        b1   <= operand_b;
        sgn1 <= in_signed;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2     <= 1'b0;
      sum2   <= '0;
      carry2 <= '0;
      sgn2   <= 1'b0;
    end else if (s2_load) begin
      v2 <= v1;
      if (v1) begin
        sum2   <= sum_row;
        carry2 <= carry_row;
        sgn2   <= sgn1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_signed <= 1'b0;
      result     <= '0;
    end else if (s3_load) begin
      out_valid <= v2;
      if (v2) begin
        result     <= sum2 + carry2;
        out_signed <= sgn2;
      end
    end
  end

endmodule
